mem_stage: RTL and testbench

- Memory-access stage directly downstream of the execute ALU. Consumes the registered ALU result, the word data address and the load/store control.
- Drives a single-port data memory over a valid/ready request channel plus a response-valid channel.
- Produces the write-back bundle for the integer/float register files.
- Stalls the whole pipeline, via n_stall, while a memory transaction is outstanding.

---
 rtl/pipe_pkg.sv | 33 +++
 rtl/mem_stage.sv | 151 +++++++++++++++
 tb/tb_mem_stage.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the integer/float pipeline stages.
//   - ex_op encoding constants driven by the execute stage
//   - mem_state_t: state of the memory-access stage FSM
//   - wb_bundle_t: write-back bundle handed to the register files
//   - rd_writes(): register-write qualification (x0 is never written)
package pipe_pkg;

    localparam logic [1:0] OP_NONE   = 2'b00;  // pass ALU result through
    localparam logic [1:0] OP_LOAD   = 2'b01;  // lw / flw
    localparam logic [1:0] OP_STORE  = 2'b10;  // sw / fsw
    localparam logic [1:0] OP_BUBBLE = 2'b11;  // reserved, behaves as a bubble

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } mem_state_t;

    typedef struct packed {
        logic        valid;
        logic        we;
        logic        fp;
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_bundle_t;

    // Integer x0 is hard-wired to zero, so a write to it is suppressed.
    // Float register f0 is an ordinary register and is always writable.
    function automatic logic rd_writes(input logic fp, input logic [4:0] rd);
        return fp || (rd != 5'd0);
    endfunction

endpackage

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage sitting directly after the execute ALU.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   ex_valid/op/fp/rd/res/daddr
//                     instruction presented by EX; sampled only while n_stall = 1
//   n_stall           1 = pipeline advances, 0 = upstream holds (stage busy)
//   wb_valid/we/fp/rd/data
//                     write-back bundle; wb_valid pulses once per retired instruction
//   mem_req/we/addr/wdata, mem_ready
//                     request channel to the single-port data memory
//   mem_rvalid, mem_rdata
//                     load response channel
//   err_oob           one-cycle pulse alongside the retire of an out-of-range access
//   dbg_state         current FSM state, for observation only
//
// Handshake: a request transfers on a rising edge where mem_req = 1 and
// mem_ready = 1. While mem_req = 1 and mem_ready = 0 the request (mem_we,
// mem_addr, mem_wdata) is held unchanged. A load response transfers on a
// rising edge where mem_rvalid = 1 while waiting in RESP; mem_rvalid in any
// other state is ignored. There is no backpressure on the response channel.
module mem_stage
    import pipe_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int DEPTH_CHK = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic [1:0]        ex_op,
    input  logic              ex_fp,
    input  logic [4:0]        ex_rd,
    input  logic [31:0]       ex_res,
    input  logic [29:0]       ex_daddr,
    output logic              n_stall,
    output logic              wb_valid,
    output logic              wb_we,
    output logic              wb_fp,
    output logic [4:0]        wb_rd,
    output logic [31:0]       wb_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic              err_oob,
    output mem_state_t        dbg_state
);

    mem_state_t        state;
    wb_bundle_t        wb;
    logic              cap_we;
    logic [ADDR_W-1:0] cap_addr;
    logic [31:0]       cap_wdata;
    logic              err_r;

    logic              take;
    logic              addr_oob;

    // A real instruction is accepted only while the stage is idle; in any
    // other state upstream is stalled and the EX inputs are just being held.
    assign take = ex_valid && (ex_op != OP_BUBBLE);

    // Any set bit above the implemented word-address width is out of range.
    // With the check disabled the upper bits are simply dropped.
    assign addr_oob = (DEPTH_CHK != 0) && ((ex_daddr >> ADDR_W) != 30'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            wb        <= '0;
            cap_we    <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            err_r     <= 1'b0;
        end else begin
            // Retire-only signals are single-cycle pulses.
            wb.valid <= 1'b0;
            wb.we    <= 1'b0;
            err_r    <= 1'b0;

            case (state)
                IDLE: begin
                    if (take) begin
                        wb.fp     <= ex_fp;
                        wb.rd     <= ex_rd;
                        cap_we    <= (ex_op == OP_STORE);
                        cap_addr  <= ex_daddr[ADDR_W-1:0];
                        cap_wdata <= ex_res;
                        if (ex_op == OP_NONE) begin
                            wb.valid <= 1'b1;
                            wb.we    <= rd_writes(ex_fp, ex_rd);
                            wb.data  <= ex_res;
                        end else if (addr_oob) begin
                            // Retire immediately without touching memory:
                            // a load returns zero, a store is dropped.
                            wb.valid <= 1'b1;
                            err_r    <= 1'b1;
                            if (ex_op == OP_LOAD) begin
                                wb.we   <= rd_writes(ex_fp, ex_rd);
                                wb.data <= 32'd0;
                            end
                        end else begin
                            state <= REQ;
                        end
                    end
                end

                REQ: begin
                    if (mem_ready) begin
                        if (cap_we) begin
                            state    <= IDLE;
                            wb.valid <= 1'b1;
                        end else begin
                            state <= RESP;
                        end
                    end
                end

                RESP: begin
                    if (mem_rvalid) begin
                        state    <= IDLE;
                        wb.valid <= 1'b1;
                        wb.we    <= rd_writes(wb.fp, wb.rd);
                        wb.data  <= mem_rdata;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign n_stall   = (state == IDLE);
    assign mem_req   = (state == REQ);
    assign mem_we    = cap_we;
    assign mem_addr  = cap_addr;
    assign mem_wdata = cap_wdata;

    assign wb_valid  = wb.valid;
    assign wb_we     = wb.we;
    assign wb_fp     = wb.fp;
    assign wb_rd     = wb.rd;
    assign wb_data   = wb.data;
    assign err_oob   = err_r;
    assign dbg_state = state;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for mem_stage (ADDR_W = 16, DEPTH_CHK = 1).
// A reference model computes each instruction's retire bundle, retire cycle
// and stall count from the behavioural rules; a monitor compares what the
// DUT presents against the expected queues. A memory responder with
// configurable ready/response delays stands in for the data memory.
module tb_mem_stage;
    import pipe_pkg::*;

    localparam int ADDR_W = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT signals ----------------
    logic              ex_valid, ex_fp;
    logic [1:0]        ex_op;
    logic [4:0]        ex_rd;
    logic [31:0]       ex_res;
    logic [29:0]       ex_daddr;
    logic              n_stall, wb_valid, wb_we, wb_fp;
    logic [4:0]        wb_rd;
    logic [31:0]       wb_data;
    logic              mem_req, mem_we, mem_ready, mem_rvalid;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata, mem_rdata;
    logic              err_oob;
    mem_state_t        dbg_state;

    mem_stage #(.ADDR_W(ADDR_W), .DEPTH_CHK(1)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_op(ex_op), .ex_fp(ex_fp), .ex_rd(ex_rd),
        .ex_res(ex_res), .ex_daddr(ex_daddr),
        .n_stall(n_stall),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_fp(wb_fp), .wb_rd(wb_rd), .wb_data(wb_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .err_oob(err_oob), .dbg_state(dbg_state)
    );

    // ---------------- scoreboard state ----------------
    // exp_q entry: {retire_cycle[15:0], err, we, fp, rd[4:0], data[31:0]}
    logic [55:0] exp_q[$];
    // req_q entry: {we, addr[15:0], wdata[31:0]}
    logic [48:0] req_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] ref_mem [int];
    logic [31:0] last_data = 32'd0;

    // Power-up content of the data memory (shared by model and responder).
    function automatic logic [31:0] init_word(input int a);
        return (32'(a) * 32'h9E37_79B1) ^ 32'h0000_5A5A;
    endfunction

    task automatic model_issue(input logic v, input logic [1:0] op, input logic fp,
                               input logic [4:0] rd, input logic [31:0] res,
                               input logic [29:0] daddr, input int rq_d, input int rs_d,
                               input int unsigned cap_cyc, output int exp_stalls);
        bit          oob, writes, we, err;
        logic [31:0] d;
        int          a;
        exp_stalls = 0;
        a      = int'(daddr);
        oob    = (a >= (1 << ADDR_W));
        writes = fp || (rd != 0);
        we     = 1'b0;
        err    = 1'b0;
        d      = last_data;
        if (v && op != 2'b11) begin
            if (op == 2'b00) begin
                we = writes;
                d  = res;
            end else if (op == 2'b01) begin
                we = writes;
                if (oob) begin
                    err = 1'b1;
                    d   = 32'd0;
                end else begin
                    d = ref_mem.exists(a) ? ref_mem[a] : init_word(a);
                    exp_stalls = 2 + rq_d + rs_d;
                    req_q.push_back({1'b0, a[15:0], res});
                end
            end else begin
                if (oob) begin
                    err = 1'b1;
                end else begin
                    ref_mem[a] = res;
                    exp_stalls = 1 + rq_d;
                    req_q.push_back({1'b1, a[15:0], res});
                end
            end
            last_data = d;
            exp_q.push_back({16'(cap_cyc + 1 + exp_stalls), err, we, fp, rd, d});
        end
    endtask

    // ---------------- memory responder ----------------
    int          cfg_req_delay = 0;
    int          cfg_rsp_delay = 0;
    logic        inject_rvalid = 1'b0;
    logic [31:0] inject_data   = 32'd0;
    logic [31:0] dmem [int];

    initial begin
        bit          req_active;
        bit          rsp_pending;
        int          req_wait, rsp_wait;
        logic [31:0] rsp_data;
        int          a;
        req_active = 0; rsp_pending = 0; req_wait = 0; rsp_wait = 0; rsp_data = 0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
        forever begin
            @(negedge clk);
            mem_ready  = 1'b0;
            mem_rvalid = inject_rvalid;
            if (inject_rvalid) mem_rdata = inject_data;
            if (!rst) begin
                req_active  = 0;
                rsp_pending = 0;
            end else if (rsp_pending) begin
                if (rsp_wait == 0) begin
                    mem_rvalid  = 1'b1;
                    mem_rdata   = rsp_data;
                    rsp_pending = 0;
                end else begin
                    rsp_wait--;
                end
            end else if (mem_req) begin
                if (!req_active) begin
                    req_active = 1;
                    req_wait   = cfg_req_delay;
                end
                if (req_wait == 0) begin
                    mem_ready  = 1'b1;
                    req_active = 0;
                    a = int'(mem_addr);
                    if (mem_we) begin
                        dmem[a] = mem_wdata;
                    end else begin
                        rsp_pending = 1;
                        rsp_wait    = cfg_rsp_delay;
                        rsp_data    = dmem.exists(a) ? dmem[a] : init_word(a);
                    end
                end else begin
                    req_wait--;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        logic [55:0] e;
        logic [48:0] r;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                if (wb_valid) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL wb_unexpected: got retire rd=%0d data=0x%0h, expected no retire (t=%0t)",
                                 wb_rd, wb_data, $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("wb_cycle", 64'(cyc[15:0]), 64'(e[55:40]));
                        check("wb_bundle", {err_oob, wb_we, wb_fp, wb_rd, wb_data}, 64'(e[39:0]));
                    end
                end else begin
                    check("idle_we_err", {wb_we, err_oob}, 2'b00);
                end
                if (mem_req) begin
                    if (req_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL mem_req_unexpected: got request addr=0x%0h, expected none (t=%0t)",
                                 mem_addr, $time);
                    end else begin
                        r = req_q[0];
                        check("mem_req_we_addr", {mem_we, mem_addr}, 64'(r[48:32]));
                        if (r[48]) check("mem_wdata", mem_wdata, r[31:0]);
                        if (mem_ready) void'(req_q.pop_front());
                    end
                end
            end
        end
    end

    // ---------------- driver ----------------
    // Called at a negedge; returns at a negedge with the stage idle again.
    task automatic issue(input logic v, input logic [1:0] op, input logic fp,
                         input logic [4:0] rd, input logic [31:0] res,
                         input logic [29:0] daddr, input int rq_d, input int rs_d);
        int stalls, exp_stalls;
        cfg_req_delay = rq_d;
        cfg_rsp_delay = rs_d;
        ex_valid = v; ex_op = op; ex_fp = fp; ex_rd = rd; ex_res = res; ex_daddr = daddr;
        @(posedge clk);
        model_issue(v, op, fp, rd, res, daddr, rq_d, rs_d, cyc, exp_stalls);
        @(negedge clk);
        ex_valid = 1'b0;
        ex_op    = 2'b00;
        stalls   = 0;
        for (int i = 0; i < 200 && !n_stall; i++) begin
            stalls++;
            @(negedge clk);
        end
        check("stall_cycles", 64'(stalls), 64'(exp_stalls));
        if (!n_stall) begin
            $display("FAIL stall_timeout: got n_stall=0 after 200 cycles, expected 1");
            n_bad++;
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
            $fatal(1, "stage hung");
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [29:0] da;
        rst = 1'b0;
        ex_valid = 1'b0; ex_op = 2'b00; ex_fp = 1'b0; ex_rd = 5'd0; ex_res = 32'd0; ex_daddr = 30'd0;
        #1;
        check("reset_n_stall", n_stall, 1'b1);
        check("reset_outputs", {mem_req, wb_valid, wb_we, err_oob, wb_data}, 36'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Pass-through, store with held-off ready, store then load.
        issue(1, 2'b00, 0, 5'd5, 32'h0000_1234, 30'h0, 0, 0);
        issue(1, 2'b10, 0, 5'd1, 32'hDEAD_BEEF, 30'h40, 3, 0);
        issue(1, 2'b10, 0, 5'd2, 32'hCAFE_0001, 30'h10, 0, 0);
        issue(1, 2'b01, 1, 5'd7, 32'h0, 30'h10, 0, 1);
        issue(1, 2'b01, 0, 5'd8, 32'h0, 30'h40, 1, 0);
        // Out-of-range and address boundaries.
        issue(1, 2'b01, 0, 5'd9, 32'h0, 30'h1_0000, 0, 0);
        issue(1, 2'b10, 0, 5'd3, 32'h1111_2222, 30'h2_0000, 0, 0);
        issue(1, 2'b10, 1, 5'd4, 32'h7777_8888, 30'hFFFF, 0, 0);
        issue(1, 2'b01, 0, 5'd10, 32'h0, 30'hFFFF, 0, 0);
        issue(1, 2'b01, 0, 5'd0, 32'h0, 30'h3FFF_FFFF, 0, 0);
        // x0 rule, float f0 is writable, bubbles.
        issue(1, 2'b00, 0, 5'd0, 32'h0000_0005, 30'h0, 0, 0);
        issue(1, 2'b00, 1, 5'd0, 32'h0000_0006, 30'h0, 0, 0);
        issue(1, 2'b01, 0, 5'd0, 32'h0, 30'h40, 0, 0);
        issue(1, 2'b11, 0, 5'd12, 32'hAAAA_0000, 30'h10, 0, 0);
        issue(0, 2'b00, 0, 5'd13, 32'hBBBB_0000, 30'h10, 0, 0);

        // Reset while a load waits for its response.
        cfg_req_delay = 0;
        cfg_rsp_delay = 20;
        ex_valid = 1'b1; ex_op = 2'b01; ex_fp = 1'b0; ex_rd = 5'd3; ex_daddr = 30'h5; ex_res = 32'h0;
        @(posedge clk);
        req_q.push_back({1'b0, 16'h0005, 32'h0});
        @(negedge clk);
        ex_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        req_q.delete();
        last_data = 32'd0;
        #1;
        check("rst_mid_load", {mem_req, wb_valid, n_stall}, 3'b001);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        inject_data   = 32'h5555_AAAA;
        inject_rvalid = 1'b1;
        @(posedge clk);
        inject_rvalid = 1'b0;
        @(negedge clk);
        check("late_rvalid_ignored", {wb_valid, n_stall}, 2'b01);
        @(negedge clk);

        // Randomized traffic.
        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 9) == 0)
                da = 30'($urandom_range(1, 16383)) << 16;
            else
                da = 30'($urandom_range(0, 31));
            issue($urandom_range(0, 7) != 0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 31)), $urandom, da,
                  $urandom_range(0, 3), $urandom_range(0, 3));
        end

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
        check("req_q_drained", 64'(req_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
